// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the data-side load/store path.
// Size encoding matches the req_size_in field; state encoding is exposed for debug.
package mem_access_pkg;

    localparam int DEF_ADDR_WIDTH      = 64;
    localparam int DEF_DATA_WIDTH      = 64;
    localparam int DEF_WORD_BYTES_2POW = 3;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsc_state_e;

endpackage

// File: rtl/load_store_controller_if.sv
// Execute-side request/response handshake plus data memory port, named from the controller's view.
// req: transfer when req_valid_in && req_ready_out; resp_valid_out is a one-cycle pulse with no backpressure.
interface load_store_controller_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic                  req_write_in;
    logic [1:0]            req_size_in;
    logic                  req_unsigned_in;
    logic [ADDR_WIDTH-1:0] req_addr_in;
    logic [DATA_WIDTH-1:0] req_wdata_in;
    logic                  resp_valid_out;
    logic [DATA_WIDTH-1:0] resp_rdata_out;
    logic                  resp_error_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_wdata_out;
    logic                  mem_we_out;
    logic                  mem_re_out;
    logic [DATA_WIDTH-1:0] mem_rdata_in;

    modport slave (
        input  req_valid_in, req_write_in, req_size_in, req_unsigned_in,
               req_addr_in, req_wdata_in, mem_rdata_in,
        output req_ready_out, resp_valid_out, resp_rdata_out, resp_error_out,
               mem_addr_out, mem_wdata_out, mem_we_out, mem_re_out
    );

    modport master (
        output req_valid_in, req_write_in, req_size_in, req_unsigned_in,
               req_addr_in, req_wdata_in, mem_rdata_in,
        input  req_ready_out, resp_valid_out, resp_rdata_out, resp_error_out,
               mem_addr_out, mem_wdata_out, mem_we_out, mem_re_out
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational little-endian lane logic: load extract/extend and sub-word store merge.
// Offsets are assumed naturally aligned for the size; misaligned requests never reach here.
module lsu_byte_lane
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int WORD_BYTES_2POW = DEF_WORD_BYTES_2POW
) (
    input  logic [DATA_WIDTH-1:0]      word_in,
    input  logic [WORD_BYTES_2POW-1:0] offset_in,
    input  logic [1:0]                 size_in,
    input  logic                       unsigned_in,
    input  logic [DATA_WIDTH-1:0]      wdata_in,
    output logic [DATA_WIDTH-1:0]      load_out,
    output logic [DATA_WIDTH-1:0]      merged_out
);
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_bit_mask;
    logic [NBYTES-1:0]     w_lane_base;
    logic [NBYTES-1:0]     w_lane_sel;
    logic                  w_sign;

    assign w_shifted = word_in >> {offset_in, 3'b000};

    always_comb begin
        w_sign   = 1'b0;
        load_out = w_shifted;
        case (size_in)
            SIZE_B: begin
                w_sign   = w_shifted[7] & ~unsigned_in;
                load_out = {{(DATA_WIDTH-8){w_sign}}, w_shifted[7:0]};
            end
            SIZE_H: begin
                w_sign   = w_shifted[15] & ~unsigned_in;
                load_out = {{(DATA_WIDTH-16){w_sign}}, w_shifted[15:0]};
            end
            SIZE_W: begin
                w_sign   = w_shifted[31] & ~unsigned_in;
                load_out = {{(DATA_WIDTH-32){w_sign}}, w_shifted[31:0]};
            end
            default: load_out = w_shifted;
        endcase
    end

    always_comb begin
        case (size_in)
            SIZE_B:  w_lane_base = NBYTES'(1);
            SIZE_H:  w_lane_base = NBYTES'(3);
            SIZE_W:  w_lane_base = NBYTES'(15);
            default: w_lane_base = '1;
        endcase
    end

    assign w_lane_sel = w_lane_base << offset_in;

    // Expand the per-byte lane select into a per-bit write mask.
    always_comb begin
        w_bit_mask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            w_bit_mask[8*i +: 8] = {8{w_lane_sel[i]}};
        end
    end

    assign merged_out = (word_in & ~w_bit_mask) | ((wdata_in << {offset_in, 3'b000}) & w_bit_mask);

endmodule

// File: rtl/load_store_controller.sv
// Data-side load/store sequencer: one outstanding access, read-modify-write for sub-word stores.
// Misaligned requests skip memory entirely and go straight to an error response.
module load_store_controller
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int WORD_BYTES_2POW = DEF_WORD_BYTES_2POW
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    load_store_controller_if.slave       bus,
    output logic [1:0]                   state_dbg_out
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_WRITE = ST_WRITE;
    localparam logic [1:0] S_RESP  = ST_RESP;

    logic [1:0]            r_state;
    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_word;

    logic [WORD_BYTES_2POW-1:0] w_align_mask;
    logic                       w_misaligned;
    logic [DATA_WIDTH-1:0]      w_load;
    logic [DATA_WIDTH-1:0]      w_merged;

    assign w_align_mask = WORD_BYTES_2POW'((32'd1 << bus.req_size_in) - 32'd1);
    assign w_misaligned = |(bus.req_addr_in[WORD_BYTES_2POW-1:0] & w_align_mask);

    lsu_byte_lane #(
        .DATA_WIDTH      (DATA_WIDTH),
        .WORD_BYTES_2POW (WORD_BYTES_2POW)
    ) u_lane (
        .word_in     (r_word),
        .offset_in   (r_addr[WORD_BYTES_2POW-1:0]),
        .size_in     (r_size),
        .unsigned_in (r_unsigned),
        .wdata_in    (r_wdata),
        .load_out    (w_load),
        .merged_out  (w_merged)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_in) begin
                        r_write    <= bus.req_write_in;
                        r_size     <= bus.req_size_in;
                        r_unsigned <= bus.req_unsigned_in;
                        r_addr     <= bus.req_addr_in;
                        r_wdata    <= bus.req_wdata_in;
                        r_err      <= w_misaligned;
                        // Full-word stores need no old data, so they skip the read.
                        if (w_misaligned)
                            r_state <= S_RESP;
                        else if (bus.req_write_in && bus.req_size_in == SIZE_D)
                            r_state <= S_WRITE;
                        else
                            r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_word  <= bus.mem_rdata_in;
                    r_state <= r_write ? S_WRITE : S_RESP;
                end
                S_WRITE: r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign state_dbg_out      = r_state;
    assign bus.req_ready_out  = (r_state == S_IDLE);
    assign bus.resp_valid_out = (r_state == S_RESP);
    assign bus.resp_error_out = (r_state == S_RESP) && r_err;
    assign bus.resp_rdata_out = ((r_state == S_RESP) && !r_write && !r_err) ? w_load : '0;
    assign bus.mem_re_out     = (r_state == S_READ);
    assign bus.mem_we_out     = (r_state == S_WRITE);
    assign bus.mem_addr_out   = (r_state == S_READ || r_state == S_WRITE)
                              ? {r_addr[ADDR_WIDTH-1:WORD_BYTES_2POW], {WORD_BYTES_2POW{1'b0}}}
                              : '0;
    assign bus.mem_wdata_out  = (r_state != S_WRITE) ? '0
                              : (r_size == SIZE_D) ? r_wdata : w_merged;

endmodule

// File: tb/tb_load_store_controller.sv
// Bench for load_store_controller: directed vector table, reset-abort sequence,
// then random traffic against a byte-level reference model of the memory.
module tb_load_store_controller;
    import mem_access_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    load_store_controller_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    load_store_controller dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .bus           (bus),
        .state_dbg_out (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stub: 16 words, asynchronous read, synchronous write.
    logic [63:0] mem [16];
    assign bus.mem_rdata_in = mem[bus.mem_addr_out[6:3]];
    always @(posedge clk) begin
        if (bus.mem_we_out) mem[bus.mem_addr_out[6:3]] <= bus.mem_wdata_out;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          rdy;
        int          resp_cyc;
        int          resp_cnt;
        int          re_cnt;
        int          we_cnt;
        logic [63:0] rdata;
        bit          err;
        logic [63:0] we_data;
        logic [63:0] we_addr;
        logic [63:0] re_addr;
    } obs_t;

    // Issue one request, then watch a fixed 5-cycle window after acceptance.
    task automatic run_req(input bit w, input logic [1:0] sz, input bit u,
                           input logic [63:0] a, input logic [63:0] wd, output obs_t o);
        o = '{default: 0};
        @(posedge clk); #1;
        bus.req_valid_in    = 1'b1;
        bus.req_write_in    = w;
        bus.req_size_in     = sz;
        bus.req_unsigned_in = u;
        bus.req_addr_in     = a;
        bus.req_wdata_in    = wd;
        @(negedge clk);
        o.rdy = bus.req_ready_out;
        @(posedge clk); #1;
        bus.req_valid_in    = 1'b0;
        bus.req_write_in    = 1'($urandom);
        bus.req_size_in     = 2'($urandom);
        bus.req_unsigned_in = 1'($urandom);
        bus.req_addr_in     = {$urandom, $urandom};
        bus.req_wdata_in    = {$urandom, $urandom};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (bus.mem_re_out) begin
                o.re_cnt++;
                o.re_addr = bus.mem_addr_out;
            end
            if (bus.mem_we_out) begin
                o.we_cnt++;
                o.we_data = bus.mem_wdata_out;
                o.we_addr = bus.mem_addr_out;
            end
            if (bus.resp_valid_out) begin
                o.resp_cnt++;
                if (o.resp_cyc == 0) begin
                    o.resp_cyc = c;
                    o.rdata    = bus.resp_rdata_out;
                    o.err      = bus.resp_error_out;
                end
            end
        end
    endtask

    // Reference: byte-granular view of the access rules.
    task automatic model(input bit w, input logic [1:0] sz, input bit u, input logic [63:0] a,
                         input logic [63:0] wd, inout logic [63:0] word,
                         output logic [63:0] rdata, output bit err,
                         output int resp, output int re, output int we);
        int nb;
        int off;
        nb    = 1 << sz;
        off   = int'(a[2:0]);
        err   = (off % nb) != 0;
        rdata = '0;
        re    = 0;
        we    = 0;
        if (err) begin
            resp = 1;
        end else if (!w) begin
            for (int i = 0; i < nb; i++) rdata[8*i +: 8] = word[8*(off+i) +: 8];
            if (!u && nb < 8 && rdata[8*nb-1])
                for (int i = nb; i < 8; i++) rdata[8*i +: 8] = 8'hFF;
            resp = 2;
            re   = 1;
        end else begin
            for (int i = 0; i < nb; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
            resp = (nb == 8) ? 2 : 3;
            re   = (nb == 8) ? 0 : 1;
            we   = 1;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        bit          exp_err;
        int          exp_resp;
        int          exp_re;
        int          exp_we;
        logic [63:0] exp_mwdata;
    } vec_t;

    vec_t        vecs [10];
    obs_t        o;
    logic [63:0] ref_mem [16];

    initial begin
        bus.req_valid_in    = 1'b0;
        bus.req_write_in    = 1'b0;
        bus.req_size_in     = 2'b00;
        bus.req_unsigned_in = 1'b0;
        bus.req_addr_in     = '0;
        bus.req_wdata_in    = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[2] = 64'h8877665544332211;

        vecs[0] = '{0, 2'd0, 0, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 0, 2, 1, 0, 64'h0};
        vecs[1] = '{0, 2'd1, 1, 64'h12, 64'h0, 64'h0000000000004433, 0, 2, 1, 0, 64'h0};
        vecs[2] = '{1, 2'd0, 0, 64'h13, 64'hAB, 64'h0, 0, 3, 1, 1, 64'h88776655AB332211};
        vecs[3] = '{0, 2'd3, 0, 64'h10, 64'h0, 64'h88776655AB332211, 0, 2, 1, 0, 64'h0};
        vecs[4] = '{1, 2'd3, 0, 64'h10, 64'h0123456789ABCDEF, 64'h0, 0, 2, 0, 1, 64'h0123456789ABCDEF};
        vecs[5] = '{0, 2'd2, 0, 64'h12, 64'h0, 64'h0, 1, 1, 0, 0, 64'h0};
        vecs[6] = '{0, 2'd2, 0, 64'h14, 64'h0, 64'h0000000001234567, 0, 2, 1, 0, 64'h0};
        vecs[7] = '{0, 2'd2, 0, 64'h10, 64'h0, 64'hFFFFFFFF89ABCDEF, 0, 2, 1, 0, 64'h0};
        vecs[8] = '{1, 2'd1, 0, 64'h11, 64'h5555, 64'h0, 1, 1, 0, 0, 64'h0};
        vecs[9] = '{1, 2'd1, 0, 64'h16, 64'hBEEF, 64'h0, 0, 3, 1, 1, 64'hBEEF456789ABCDEF};

        // Reset state, checked while reset is held and just after release.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready_out), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid_out), 64'd0);
        chk("rst_resp_err", 64'(bus.resp_error_out), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata_out, 64'd0);
        chk("rst_re", 64'(bus.mem_re_out), 64'd0);
        chk("rst_we", 64'(bus.mem_we_out), 64'd0);
        chk("rst_addr", bus.mem_addr_out, 64'd0);
        chk("rst_wdata", bus.mem_wdata_out, 64'd0);
        chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready_out), 64'd1);

        foreach (vecs[k]) begin
            run_req(vecs[k].wr, vecs[k].sz, vecs[k].uns, vecs[k].addr, vecs[k].wdata, o);
            chk($sformatf("v%0d_ready", k), 64'(o.rdy), 64'd1);
            chk($sformatf("v%0d_resp_cycle", k), 64'(o.resp_cyc), 64'(vecs[k].exp_resp));
            chk($sformatf("v%0d_resp_count", k), 64'(o.resp_cnt), 64'd1);
            chk($sformatf("v%0d_re_cycles", k), 64'(o.re_cnt), 64'(vecs[k].exp_re));
            chk($sformatf("v%0d_we_cycles", k), 64'(o.we_cnt), 64'(vecs[k].exp_we));
            chk($sformatf("v%0d_rdata", k), o.rdata, vecs[k].exp_rdata);
            chk($sformatf("v%0d_err", k), 64'(o.err), 64'(vecs[k].exp_err));
            if (vecs[k].exp_we != 0) begin
                chk($sformatf("v%0d_we_data", k), o.we_data, vecs[k].exp_mwdata);
                chk($sformatf("v%0d_we_addr", k), o.we_addr, 64'h10);
            end
            if (vecs[k].exp_re != 0) chk($sformatf("v%0d_re_addr", k), o.re_addr, 64'h10);
        end
        chk("table_mem_word", mem[2], 64'hBEEF456789ABCDEF);

        // Reset during the READ of a half store: write suppressed, no response.
        @(posedge clk); #1;
        bus.req_valid_in    = 1'b1;
        bus.req_write_in    = 1'b1;
        bus.req_size_in     = 2'd1;
        bus.req_unsigned_in = 1'b0;
        bus.req_addr_in     = 64'h10;
        bus.req_wdata_in    = 64'h1234;
        @(posedge clk); #1;
        bus.req_valid_in = 1'b0;
        chk("abort_in_read", 64'(bus.mem_re_out), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready_async", 64'(bus.req_ready_out), 64'd1);
        chk("abort_re_async", 64'(bus.mem_re_out), 64'd0);
        chk("abort_we_async", 64'(bus.mem_we_out), 64'd0);
        begin
            int we_seen;
            int resp_seen;
            we_seen   = 0;
            resp_seen = 0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (bus.mem_we_out) we_seen++;
                if (bus.resp_valid_out) resp_seen++;
            end
            chk("abort_no_write", 64'(we_seen), 64'd0);
            chk("abort_no_resp", 64'(resp_seen), 64'd0);
            chk("abort_ready_after", 64'(bus.req_ready_out), 64'd1);
            chk("abort_mem_unchanged", mem[2], 64'hBEEF456789ABCDEF);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 16; i++) begin
            mem[i]     = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        for (int t = 0; t < 200; t++) begin
            bit          w;
            bit          u;
            logic [1:0]  sz;
            logic [63:0] a;
            logic [63:0] wd;
            logic [63:0] exp_rd;
            bit          exp_err;
            int          exp_resp;
            int          exp_re;
            int          exp_we;
            w  = 1'($urandom);
            u  = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            wd = {$urandom, $urandom};
            model(w, sz, u, a, wd, ref_mem[a[6:3]], exp_rd, exp_err, exp_resp, exp_re, exp_we);
            run_req(w, sz, u, a, wd, o);
            chk($sformatf("r%0d_ready", t), 64'(o.rdy), 64'd1);
            chk($sformatf("r%0d_resp_cycle", t), 64'(o.resp_cyc), 64'(exp_resp));
            chk($sformatf("r%0d_resp_count", t), 64'(o.resp_cnt), 64'd1);
            chk($sformatf("r%0d_err", t), 64'(o.err), 64'(exp_err));
            chk($sformatf("r%0d_rdata", t), o.rdata, exp_rd);
            chk($sformatf("r%0d_re_cycles", t), 64'(o.re_cnt), 64'(exp_re));
            chk($sformatf("r%0d_we_cycles", t), 64'(o.we_cnt), 64'(exp_we));
            if (exp_we != 0) chk($sformatf("r%0d_we_data", t), o.we_data, ref_mem[a[6:3]]);
        end
        for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_controller.md
Name: load_store_controller

Overview:
- Sequences all data-side accesses to the word-addressable data memory: asynchronous read, synchronous full-word write, 2^WORD_BYTES_2POW-byte words.
- Provides byte, halfword, word and doubleword loads and stores. Loads use little-endian lane extraction with sign or zero extension. Sub-word stores use a read-modify-write of the containing word.
- Sits between the execute stage (request/response handshake) and the data memory port.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, data bus and memory word width.
- WORD_BYTES_2POW, 3, log2 of bytes per word. Byte offset is addr[WORD_BYTES_2POW-1:0].

Ports:
- clk_in  input  1  clock. All state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  controller can accept a request.
- req_write_in  input  1  1 = store, 0 = load.
- req_size_in  input  2  00 byte, 01 half, 10 word, 11 dword.
- req_unsigned_in  input  1  zero-extend the load result. Ignored for stores and for dword.
- req_addr_in  input  ADDR_WIDTH  byte address.
- req_wdata_in  input  DATA_WIDTH  store data, right-justified.
- resp_valid_out  output  1  one-cycle response pulse.
- resp_rdata_out  output  DATA_WIDTH  extended load data. 0 for stores and errors.
- resp_error_out  output  1  misaligned access, qualified by resp_valid_out.
- mem_addr_out  output  ADDR_WIDTH  word-aligned byte address (low WORD_BYTES_2POW bits forced to 0).
- mem_wdata_out  output  DATA_WIDTH  merged word to write.
- mem_we_out  output  1  memory write enable.
- mem_re_out  output  1  memory read enable.
- mem_rdata_in  input  DATA_WIDTH  asynchronous memory read data.

Behaviour:
- **Reset (asynchronous, immediate):**
  - State goes to IDLE; all captured request registers clear to 0.
  - req_ready_out=1; resp_valid_out=0, resp_error_out=0, resp_rdata_out=0.
  - mem_we_out=0, mem_re_out=0, mem_addr_out=0, mem_wdata_out=0.
- **FSM states:** IDLE, READ, WRITE, RESP.
- **Handshake:**
  - Accept when req_valid_in && req_ready_out.
  - req_ready_out=1 only in IDLE, so at most one access is outstanding.
  - All request fields are captured at acceptance; inputs are don't-care afterwards.
- **Alignment check at accept:** misaligned when (addr & ((1<<size)-1)) != 0.
  - Misaligned request: IDLE→RESP with resp_error_out=1 and resp_rdata_out=0.
  - No mem_re_out or mem_we_out is ever asserted for it.
- **Load:** IDLE→READ→RESP.
  - In READ: mem_re_out=1; mem_rdata_in is sampled into the word register at the end of the cycle.
  - RESP is 2 cycles after accept.
- **Sub-word store (size<11):** IDLE→READ→WRITE→RESP.
  - READ latches the old word.
  - WRITE drives mem_we_out=1 for exactly one cycle with the merged word.
  - RESP is 3 cycles after accept.
- **Dword store:** IDLE→WRITE→RESP. No read; mem_wdata_out equals the captured wdata.
- **Merge rule** (off = byte offset, nb = 1<<size):
  - bytemask = ((1<<nb)-1) << off; expand bytemask to a bit mask M.
  - new = (old & ~M) | ((wdata << 8*off) & M).
- **Load extraction:**
  - v = (word >> 8*off) truncated to 8*nb bits.
  - Sign-extend from bit 8*nb-1 unless req_unsigned_in=1; then zero-extend.
- **RESP:** lasts exactly one cycle, then returns to IDLE. There is no response backpressure; the requester must consume the pulse.
- **Idle outputs:** mem_re_out and mem_we_out are 0 outside READ and WRITE respectively. mem_addr_out holds the captured aligned address in READ and WRITE, and is 0 otherwise.
- **Reset mid-operation:** the access is abandoned. A reset asserted before the WRITE-cycle clock edge suppresses the write (mem_we_out drops immediately), and no response is issued.
- A new request can be accepted in the cycle after RESP, since IDLE is re-entered then.

Decomposition:
- Package mem_access_pkg:
  - size typedef enum {SIZE_B, SIZE_H, SIZE_W, SIZE_D}.
  - FSM state enum.
  - Default width constants.
- Sub-module lsu_byte_lane: purely combinational extract/extend and merge logic (inputs: word, offset, size, unsigned, wdata; outputs: load value, merged word).
- The FSM and request registers stay in load_store_controller.

Test Plan:
- Memory word at 0x10 = 0x8877665544332211; signed byte load at 0x17 → resp 2 cycles after accept, rdata 0xFFFFFFFFFFFFFF88, error 0.
- Unsigned half load at 0x12 → rdata 0x0000000000004433, mem_re_out high exactly one cycle.
- Byte store 0xAB at 0x13 → mem_we_out one cycle with mem_wdata_out 0x88776655AB332211; resp at cycle 3; a re-read returns that word.
- Dword store 0x0123456789ABCDEF at 0x10 → mem_re_out never asserted, write at cycle 1, resp at cycle 2.
- Word load at 0x12 (misaligned) → resp at cycle 1 with error 1 and rdata 0; no mem_re_out or mem_we_out.
- rst_in pulsed during READ of a half store → mem_we_out never asserts, word unchanged, req_ready_out=1 after release, no resp_valid_out.
